// File: rtl/ks_pkg.sv
// Shared types and constants for the multi-precision Kogge-Stone add/sub sequencer.
package ks_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/ks_adder.sv
// Combinational 8-bit Kogge-Stone adder: log2(8)=3 prefix levels over generate/propagate pairs.
module KS_adder
    import ks_pkg::*;
(
    input  logic [BYTE_W-1:0] A,
    input  logic [BYTE_W-1:0] B,
    input  logic              Cin,
    output logic [BYTE_W-1:0] S,
    output logic              Cout
);

    logic [BYTE_W-1:0] g0, p0, g1, p1, g2, p2, g3, p3;
    logic [BYTE_W:0]   c;

    // Group (g,p) at level k spans 2^k bits; the carry-in is folded in after the prefix tree.
    always_comb begin
        g0 = A & B;
        p0 = A ^ B;

        g1 = g0;
        p1 = p0;
        for (int i = 1; i < BYTE_W; i++) begin
            g1[i] = g0[i] | (p0[i] & g0[i-1]);
            p1[i] = p0[i] & p0[i-1];
        end

        g2 = g1;
        p2 = p1;
        for (int i = 2; i < BYTE_W; i++) begin
            g2[i] = g1[i] | (p1[i] & g1[i-2]);
            p2[i] = p1[i] & p1[i-2];
        end

        g3 = g2;
        p3 = p2;
        for (int i = 4; i < BYTE_W; i++) begin
            g3[i] = g2[i] | (p2[i] & g2[i-4]);
            p3[i] = p2[i] & p2[i-4];
        end

        c[0] = Cin;
        for (int i = 0; i < BYTE_W; i++) begin
            c[i+1] = g3[i] | (p3[i] & Cin);
        end

        S    = p0 ^ c[BYTE_W-1:0];
        Cout = c[BYTE_W];
    end

endmodule

// File: rtl/ks_mp_add_seq.sv
// Byte-serial multi-precision add/subtract: one shared 8-bit Kogge-Stone adder,
// LSB byte first, carry chained through a register between cycles.
module ks_mp_add_seq
    import ks_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int W      = BYTE_W * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_sub,
    input  logic         in_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovf,
    output logic         busy
);

    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    state_t state, state_next;

    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_eff;
    logic              carry;
    logic [IDXW-1:0]   idx;
    logic [BYTE_W-1:0] a_byte, b_byte, s_byte;
    logic              cout_byte;
    logic              last_byte;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign last_byte = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_byte) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Byte-select muxes feeding the shared adder.
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == IDXW'(i)) begin
                a_byte = a_reg[i*BYTE_W +: BYTE_W];
                b_byte = b_eff[i*BYTE_W +: BYTE_W];
            end
        end
    end

    KS_adder u_adder (
        .A    (a_byte),
        .B    (b_byte),
        .Cin  (carry),
        .S    (s_byte),
        .Cout (cout_byte)
    );

    // Subtract is A + ~B + 1, so the inversion and the forced carry are captured at accept time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_eff    <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= in_a;
                        b_eff   <= in_sub ? ~in_b : in_b;
                        carry   <= in_sub ? 1'b1 : in_cin;
                        idx     <= '0;
                        out_sum <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (idx == IDXW'(i)) out_sum[i*BYTE_W +: BYTE_W] <= s_byte;
                    end
                    carry <= cout_byte;
                    if (last_byte) begin
                        out_cout <= cout_byte;
                        out_ovf  <= (a_reg[W-1] == b_eff[W-1]) & (s_byte[BYTE_W-1] != a_reg[W-1]);
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ks_mp_add_seq.sv
// Scoreboard bench for ks_mp_add_seq with NBYTES=4: directed add/sub, backpressure, mid-run reset, random back-to-back.
module tb_ks_mp_add_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];

    ks_mp_add_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference from plain wide arithmetic; subtract's carry means "no borrow".
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin);
        logic [W:0] r;
        exp_t e;
        if (sub) begin
            r     = {1'b0, a} - {1'b0, b};
            e.ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            e.cout = (a >= b);
        end else begin
            r     = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            e.ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            e.cout = r[W];
        end
        e.sum = r[W-1:0];
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                           input logic cin, input exp_t e, output int acc_cyc);
        int t = 0;
        while (!in_ready && t < 20) begin
            step();
            t++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL push_ready: in_ready=%b required 1", in_ready);
        end
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_cin   = cin;
        in_valid = 1'b1;
        step();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        sb.push_back(e);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        #12;
        n_checks++;
        if ({in_ready, out_valid, busy, out_sum, out_cout, out_ovf} !== {3'b100, {W{1'b0}}, 2'b00}) begin
            n_fail++;
            $display("[TB] FAIL reset_state: rdy=%b vld=%b busy=%b sum=%h c=%b o=%b required 1 0 0 0 0 0",
                     in_ready, out_valid, busy, out_sum, out_cout, out_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        logic [W-1:0] ta[3] = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF};
        logic [W-1:0] tb[3] = '{32'h00000001, 32'h00000001, 32'h00000000};
        logic         tc[3] = '{1'b0, 1'b0, 1'b1};
        exp_t         te[3] = '{{32'h00000100, 1'b0, 1'b0},
                                {32'h00000000, 1'b1, 1'b0},
                                {32'h80000000, 1'b0, 1'b1}};
        int   lat, acc;
        exp_t e;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_op(ta[k], tb[k], 1'b0, tc[k], te[k], acc);
            wait_valid(lat);
            e = sb.pop_front();
            n_checks++;
            if (lat !== NB) begin
                n_fail++;
                $display("[TB] FAIL add_latency[%0d]: got %0d edges required %0d", k, lat, NB);
            end
            n_checks++;
            if ({out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf}) begin
                n_fail++;
                $display("[TB] FAIL add_result[%0d]: sum=%h c=%b o=%b required sum=%h c=%b o=%b",
                         k, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
            end
            step();
        end
    endtask

    task automatic test_sub();
        logic [W-1:0] ta[3] = '{32'h00000005, 32'h80000000, 32'h00000005};
        logic [W-1:0] tb[3] = '{32'h00000007, 32'h00000001, 32'h00000007};
        logic         tc[3] = '{1'b0, 1'b0, 1'b1};
        exp_t         te[3] = '{{32'hFFFFFFFE, 1'b0, 1'b0},
                                {32'h7FFFFFFF, 1'b1, 1'b1},
                                {32'hFFFFFFFE, 1'b0, 1'b0}};
        int   lat, acc;
        exp_t e;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_op(ta[k], tb[k], 1'b1, tc[k], te[k], acc);
            wait_valid(lat);
            e = sb.pop_front();
            n_checks++;
            if (lat < 0 || {out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf}) begin
                n_fail++;
                $display("[TB] FAIL sub_result[%0d]: lat=%0d sum=%h c=%b o=%b required sum=%h c=%b o=%b",
                         k, lat, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int   lat, acc;
        exp_t e;
        out_ready = 1'b0;
        push_op(32'h00001234, 32'h00001111, 1'b0, 1'b0, '{32'h00002345, 1'b0, 1'b0}, acc);
        wait_valid(lat);
        e = sb.pop_front();
        in_a     = 32'h89ABCDEF;
        in_b     = 32'h76543211;
        in_sub   = 1'b0;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({out_valid, in_ready, out_sum, out_cout, out_ovf} !== {1'b1, 1'b0, e.sum, e.cout, e.ovf}) begin
                n_fail++;
                $display("[TB] FAIL bp_hold[%0d]: vld=%b rdy=%b sum=%h c=%b o=%b required 1 0 %h %b %b",
                         k, out_valid, in_ready, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL bp_release: rdy=%b vld=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL bp_accept: busy=%b required 1", busy);
        end
        sb.push_back('{32'h00000000, 1'b1, 1'b0});
        out_ready = 1'b1;
        wait_valid(lat);
        e = sb.pop_front();
        n_checks++;
        if (lat !== NB || {out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf}) begin
            n_fail++;
            $display("[TB] FAIL bp_second: lat=%0d sum=%h c=%b o=%b required lat=%0d sum=%h c=%b o=%b",
                     lat, out_sum, out_cout, out_ovf, NB, e.sum, e.cout, e.ovf);
        end
        step();
    endtask

    task automatic test_reset_midrun();
        int   lat, acc;
        exp_t e;
        out_ready = 1'b1;
        push_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, model(32'h12345678, 32'h11111111, 1'b0, 1'b0), acc);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, out_sum, out_cout, out_ovf} !== {3'b100, {W{1'b0}}, 2'b00}) begin
            n_fail++;
            $display("[TB] FAIL midrun_reset: rdy=%b vld=%b busy=%b sum=%h c=%b o=%b required 1 0 0 0 0 0",
                     in_ready, out_valid, busy, out_sum, out_cout, out_ovf);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        push_op(32'h00000001, 32'h00000002, 1'b0, 1'b0, '{32'h00000003, 1'b0, 1'b0}, acc);
        wait_valid(lat);
        e = sb.pop_front();
        n_checks++;
        if (lat < 0 || {out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf}) begin
            n_fail++;
            $display("[TB] FAIL after_reset_op: lat=%0d sum=%h c=%b o=%b required sum=%h c=%b o=%b",
                     lat, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int acc_prev;
        out_ready = 1'b1;
        acc_prev  = 0;
        fork
            begin
                logic [W-1:0] a, b;
                logic         sub, cin;
                int           acc;
                for (int k = 0; k < 20; k++) begin
                    a   = $urandom;
                    b   = $urandom;
                    sub = 1'($urandom_range(0, 1));
                    cin = 1'($urandom_range(0, 1));
                    push_op(a, b, sub, cin, model(a, b, sub, cin), acc);
                    if (k > 0) begin
                        n_checks++;
                        if (acc - acc_prev !== NB + 2) begin
                            n_fail++;
                            $display("[TB] FAIL b2b_spacing[%0d]: got %0d cycles required %0d",
                                     k, acc - acc_prev, NB + 2);
                        end
                    end
                    acc_prev = acc;
                end
            end
            begin
                int   lat;
                exp_t e;
                for (int k = 0; k < 20; k++) begin
                    wait_valid(lat);
                    n_checks++;
                    if (lat < 0 || sb.size() == 0) begin
                        n_fail++;
                        $display("[TB] FAIL b2b_timeout[%0d]: lat=%0d queued=%0d required a result", k, lat, sb.size());
                        break;
                    end
                    e = sb.pop_front();
                    if ({out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf}) begin
                        n_fail++;
                        $display("[TB] FAIL b2b_result[%0d]: sum=%h c=%b o=%b required sum=%h c=%b o=%b",
                                 k, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
                    end
                    step();
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ks_mp_add_seq.md
# ks_mp_add_seq

Multi-precision add/subtract sequencer for the accelerator's accumulation path. It accepts one wide operand pair through a valid/ready handshake. It then streams the operands one byte per cycle, least-significant byte first, through a single shared 8-bit Kogge-Stone adder, chaining the carry in a register. The result is presented through a valid/ready output handshake. It trades latency for area, so wide sums never need a wide parallel adder.

## Interface
- NBYTES, 4: operand width in bytes, ≥1; word width W = 8*NBYTES.

- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept; high only in IDLE.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_sub  in  1  1: A−B; 0: A+B+in_cin.
- in_cin  in  1  carry-in for add; ignored when in_sub=1.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_sum  out  W  result, modulo 2^W.
- out_cout  out  1  final carry; for subtract, 1 = no borrow (A ≥ B unsigned).
- out_ovf  out  1  signed two's-complement overflow.
- busy  out  1  high in RUN or DONE.

One clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a=in_a and b_eff = in_sub ? ~in_b : in_b.
  - Set carry = in_sub ? 1 : in_cin, idx=0, out_sum=0, and go to RUN.
- RUN, each cycle:
  - Adder inputs: A=a[idx*8+:8], B=b_eff[idx*8+:8], Cin=carry.
  - Register the adder's S into out_sum[idx*8+:8]; carry ← Cout; idx ← idx+1.
  - On the edge processing idx=NBYTES−1:
    - out_cout ← Cout.
    - out_ovf ← (a[W−1]==b_eff[W−1]) & (S[7]!=a[W−1]).
    - out_valid ← 1; go to DONE.
- DONE:
  - out_sum, out_cout and out_ovf are held stable while out_valid=1.
  - in_ready=0; in_valid is ignored.
  - On out_valid&out_ready: out_valid ← 0; go to IDLE. out_sum, out_cout and out_ovf keep their values until the next accept.
- idx counter is $clog2(NBYTES) bits, with a minimum of 1. It never wraps past NBYTES−1.
- NBYTES=1: RUN lasts one cycle; the result equals a single adder pass.
- Reset values, applied immediately on rst_n low in any state, including mid-RUN; a partial result is discarded:
  - state=IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - out_sum=0, out_cout=0, out_ovf=0.
  - Internal idx, carry, a and b_eff all 0.

## Timing
- Accept edge = E0. Bytes are processed on edges E1..E_NBYTES. out_valid is high from the cycle after E_NBYTES.
- Latency: NBYTES edges from accept to out_valid.
- With out_ready held high, DONE lasts 1 cycle and IDLE is reached after edge E_NBYTES+1. The next accept is at E_NBYTES+2, so throughput is one operation per NBYTES+2 cycles.
- in_ready and busy are decoded from registered state only; there is no combinational path from in_valid or out_ready to any output.
- The adder is purely combinational between the byte-select muxes and the out_sum/carry registers, giving a single-cycle path.

## Structure
- Shared package ks_pkg:
  - state enum {IDLE, RUN, DONE}.
  - localparam BYTE_W=8.
- One sub-module: the team's existing combinational 8-bit Kogge-Stone adder, KS_adder.
  - Ports used: A, B, Cin, S, Cout.
  - Instantiated once.
- Everything else in this module: the FSM, idx counter, carry register, operand registers and output registers.

## Test plan
All scenarios use NBYTES=4.
- Add: A=0x000000FF, B=0x00000001, sub=0, cin=0 → out_sum=0x00000100, cout=0, ovf=0. out_valid rises 4 edges after accept.
- Full ripple: A=0xFFFFFFFF, B=0x00000001 → out_sum=0x00000000, cout=1, ovf=0. A=0x7FFFFFFF, B=0, cin=1 → out_sum=0x80000000, ovf=1, cout=0.
- Subtract:
  - A=5, B=7 → out_sum=0xFFFFFFFE, cout=0, ovf=0.
  - A=0x80000000, B=1 → out_sum=0x7FFFFFFF, cout=1, ovf=1.
  - With cin=1, result unchanged (cin ignored).
- Backpressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 and a new pair offered.
  - Outputs stay stable; in_ready=0; the pair is not consumed.
  - After the out_ready handshake, the pair is accepted on the first IDLE cycle.
  - The second result is correct.
- Reset mid-RUN: assert rst_n=0 after 2 bytes are processed.
  - All outputs take their reset values asynchronously, before the next clock edge.
  - After release, a fresh op A=1, B=2 yields out_sum=3.
- Back-to-back: 20 random ops with out_ready=1 → results match a reference model. Accepts are spaced exactly NBYTES+2 cycles apart.
